// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency ROM reads and
// buffers returned words in a small FIFO whose head is presented to decode.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        irom_en,
   output logic [31:0] irom_addr,
   input  logic [31:0] irom_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [31:0] id_inst,
   output logic        fetch_err
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   pc;
   logic          inflight;
   logic [31:0]   inflight_pc;
   logic [CW-1:0] count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   mem_pc   [FIFO_DEPTH];
   logic [31:0]   mem_inst [FIFO_DEPTH];

   logic          pop;
   logic          push;
   logic          redirect_ok;
   logic [CW:0]   level;
   logic          issue_ok;
   logic [31:0]   head_pc;

   // Decode handshake: an entry transfers on a cycle where id_valid=1 and
   // stall=0 (stall is the inverse of ready); a redirect cancels the transfer.
   assign pop         = id_valid & ~stall & ~redirect;
   // The response returning during a redirect cycle belongs to the old path.
   assign push        = inflight & ~redirect;
   assign redirect_ok = redirect & (redirect_pc[1:0] == 2'b00);
   assign level       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue_ok    = level < DEPTH_L;

   // rst_n gates the request so the ROM sees nothing while reset is held.
   always_comb begin
      irom_en   = 1'b0;
      irom_addr = pc;
      if (rst_n) begin
         if (redirect) begin
            irom_en   = redirect_ok;
            irom_addr = redirect_pc;
         end else if (!fetch_err && issue_ok) begin
            irom_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 32'h0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fetch_err   <= 1'b0;
      end else begin
         inflight    <= irom_en;
         inflight_pc <= irom_addr;
         if (redirect) begin
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fetch_err <= ~redirect_ok;
            if (redirect_ok) begin
               pc <= redirect_pc + 32'd4;
            end
         end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            if (irom_en) begin
               pc <= pc + 32'd4;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]   <= inflight_pc;
         mem_inst[wr_ptr] <= irom_rdata;
      end
   end

   assign id_valid = (count != '0);
   assign head_pc  = mem_pc[rd_ptr];
   assign id_pc    = id_valid ? head_pc : 32'h0;
   assign id_pc4   = id_pc + 32'd4;
   assign id_inst  = id_valid ? mem_inst[rd_ptr] : NOP_INST;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random stall/redirect traffic,
// checked against a program-order scoreboard of expected decode PCs.
module tb_if_fetch_stage;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        irom_en, id_valid, fetch_err, stall, redirect;
   logic [31:0] irom_addr, irom_rdata, redirect_pc, id_pc, id_pc4, id_inst;
   logic        w_irom_en, w_id_valid, w_fetch_err;
   logic [31:0] w_irom_addr, w_irom_rdata, w_id_pc, w_id_pc4, w_id_inst;

   if_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .irom_en(irom_en), .irom_addr(irom_addr),
      .irom_rdata(irom_rdata), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .id_valid(id_valid), .id_pc(id_pc),
      .id_pc4(id_pc4), .id_inst(id_inst), .fetch_err(fetch_err)
   );

   // Second instance exercises PC wrap-around from a high reset vector.
   if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut_w (
      .clk(clk), .rst_n(rst_n), .irom_en(w_irom_en), .irom_addr(w_irom_addr),
      .irom_rdata(w_irom_rdata), .stall(1'b0), .redirect(1'b0),
      .redirect_pc(32'h0), .id_valid(w_id_valid), .id_pc(w_id_pc),
      .id_pc4(w_id_pc4), .id_inst(w_id_inst), .fetch_err(w_fetch_err)
   );

   // Synchronous ROM models: word = addr | 1, one cycle after the request.
   always @(posedge clk) begin
      if (irom_en)   irom_rdata   <= irom_addr | 32'h1;
      if (w_irom_en) w_irom_rdata <= w_irom_addr | 32'h1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   logic [31:0] exp_q[$];
   logic [31:0] exp_fetch;
   int          age;
   logic        err;
   int          cyc;
   logic [31:0] w_exp[3];

   // Values sampled in the last cycle, for directed checks
   logic        s_en, s_valid, s_err;
   logic [31:0] s_addr, s_pc;

   task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
      logic        exp_valid;
      logic [31:0] head;
      logic        aligned;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      @(negedge clk);
      exp_valid = !err && (age >= 2);
      aligned   = (rpc[1:0] == 2'b00);
      check("id_valid", id_valid, exp_valid);
      check("fetch_err", fetch_err, err);
      if (id_valid) begin
         head = (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF;
         check("id_pc", id_pc, head);
         check("id_inst", id_inst, head | 32'h1);
         check("id_pc4", id_pc4, head + 32'd4);
      end else begin
         check("id_inst_nop", id_inst, NOP);
      end
      if (rd) begin
         check("redir_en", irom_en, aligned);
         if (aligned) check("redir_addr", irom_addr, rpc);
      end else if (err) begin
         check("err_en", irom_en, 1'b0);
      end else if (irom_en) begin
         check("fetch_addr", irom_addr, exp_fetch);
      end
      if (cyc >= 2 && cyc <= 4) begin
         check("w_id_pc", w_id_pc, w_exp[cyc-2]);
         check("w_id_pc4", w_id_pc4, w_exp[cyc-2] + 32'd4);
      end
      s_en = irom_en; s_addr = irom_addr; s_valid = id_valid; s_err = fetch_err; s_pc = id_pc;
      if (rd) begin
         exp_q.delete();
         if (aligned) begin
            err = 1'b0;
            age = 1;
            exp_q.push_back(rpc);
            exp_fetch = rpc + 32'd4;
         end else begin
            err = 1'b1;
         end
      end else begin
         if (exp_valid && !st && exp_q.size() != 0) void'(exp_q.pop_front());
         if (irom_en && !err) begin
            exp_q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
         end
         age++;
      end
      check("outstanding", 32'(exp_q.size() <= DEPTH), 32'd1);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      int          sel;
      w_exp[0] = 32'hFFFF_FFF8; w_exp[1] = 32'hFFFF_FFFC; w_exp[2] = 32'h0000_0000;
      stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      exp_fetch = 32'h0; age = 0; err = 1'b0; cyc = 0;

      // Reset state while rst_n is held low
      #12;
      check("rst_valid", id_valid, 1'b0);
      check("rst_en", irom_en, 1'b0);
      check("rst_inst", id_inst, NOP);
      check("rst_pc", id_pc, 32'h0);
      check("rst_pc4", id_pc4, 32'h4);
      check("rst_err", fetch_err, 1'b0);
      check("rst_w_en", w_irom_en, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Sequential fetch after reset release
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 32'h0);
         check("t1_en", s_en, 1'b1);
         check("t1_addr", s_addr, 32'(4 * i));
         if (i == 1) check("t1_latency", s_valid, 1'b0);
      end

      // Stall with head pc 8: head held, fetch throttled
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 32'h0);
         check("t2_hold", s_pc, 32'h8);
         check("t2_en_off", s_en, 1'b0);
      end
      cycle(1'b0, 1'b0, 32'h0);
      check("t2_resume", s_pc, 32'h8);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);

      // Redirect with a full FIFO
      cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'h100);
      cycle(1'b0, 1'b0, 32'h0);
      check("t3_bubble", s_valid, 1'b0);
      cycle(1'b0, 1'b0, 32'h0);
      check("t3_target", s_pc, 32'h100);
      cycle(1'b0, 1'b0, 32'h0);
      check("t3_next", s_pc, 32'h104);

      // Redirect beats stall
      cycle(1'b1, 1'b1, 32'h40);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      check("t4_target", s_pc, 32'h40);

      // Misaligned target halts fetch; aligned target recovers
      cycle(1'b0, 1'b1, 32'h102);
      cycle(1'b0, 1'b0, 32'h0);
      check("t5_err", s_err, 1'b1);
      check("t5_en", s_en, 1'b0);
      check("t5_valid", s_valid, 1'b0);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'h200);
      cycle(1'b0, 1'b0, 32'h0);
      check("t5_clear", s_err, 1'b0);
      cycle(1'b0, 1'b0, 32'h0);
      check("t5_target", s_pc, 32'h200);

      // Random stall / redirect traffic
      for (int i = 0; i < 400; i++) begin
         r   = $urandom;
         sel = $urandom_range(0, 3);
         if (sel == 0)      r = 32'hFFFF_FFF0 + {28'h0, r[1:0], 2'b00};
         else if (sel == 1) r[1:0] = 2'($urandom_range(1, 3));
         else               r[1:0] = 2'b00;
         cycle($urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0, r);
      end

      // Asynchronous reset assertion mid-cycle
      cycle(1'b0, 1'b1, 32'h300);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", id_valid, 1'b0);
      check("arst_en", irom_en, 1'b0);
      check("arst_inst", id_inst, NOP);
      check("arst_pc4", id_pc4, 32'h4);
      check("arst_w_valid", w_id_valid, 1'b0);
      check("arst_w_en", w_irom_en, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
